// File: rtl/grf_write_sched_if.sv
// grf_write_sched_if: pipeline/late write requests, register-file write port and pending-write query.
interface grf_write_sched_if;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic [31:0] p_pc;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pc;
  logic        WEnable;
  logic [4:0]  WAddr;
  logic [31:0] WData;
  logic [31:0] IAddr;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_hit1;
  logic        q_hit2;
  logic        starve;
  logic [4:0]  count;
  modport master (
    output p_valid, p_addr, p_data, p_pc, m_valid, m_addr, m_data, m_pc, q_addr1, q_addr2,
    input  m_ready, WEnable, WAddr, WData, IAddr, q_hit1, q_hit2, starve, count
  );
  modport slave (
    input  p_valid, p_addr, p_data, p_pc, m_valid, m_addr, m_data, m_pc, q_addr1, q_addr2,
    output m_ready, WEnable, WAddr, WData, IAddr, q_hit1, q_hit2, starve, count
  );
endinterface

// File: rtl/grf_write_sched.sv
// grf_write_sched: single register-file write port shared by the pipeline and a late-write FIFO.
// Optional GRF_WRITE_TRACE_EN prints one trace line per issued write.
module grf_write_sched #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic reset,
  grf_write_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    aq [DEPTH];
  logic [31:0]   dq [DEPTH];
  logic [31:0]   pq [DEPTH];
  logic [DEPTH-1:0] v;
  logic [AW-1:0] rd, wr;
  logic [4:0]    cnt;
  logic [WW-1:0] wt;
  logic          sel_p, pop, push, h1, h2;
  assign sel_p = bus.p_valid && bus.p_addr != 5'd0;
  assign pop = !sel_p && cnt != 5'd0;
  assign bus.m_ready = !reset && cnt < 5'(DEPTH);
  assign push = bus.m_valid && bus.m_ready && bus.m_addr != 5'd0;
  assign bus.count = cnt;
  assign bus.starve = wt == WW'(STARVE_LIMIT);
  always_comb begin
    h1 = 1'b0;
    h2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      h1 = h1 | (v[i] && aq[i] == bus.q_addr1);
      h2 = h2 | (v[i] && aq[i] == bus.q_addr2);
    end
  end
  assign bus.q_hit1 = h1 && bus.q_addr1 != 5'd0;
  assign bus.q_hit2 = h2 && bus.q_addr2 != 5'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.WEnable <= 1'b0;
      bus.WAddr <= 5'd0;
      bus.WData <= 32'd0;
      bus.IAddr <= 32'd0;
      v <= '0;
      rd <= '0;
      wr <= '0;
      cnt <= 5'd0;
      wt <= '0;
    end else begin
      bus.WEnable <= sel_p || pop;
      if (sel_p) begin
        bus.WAddr <= bus.p_addr;
        bus.WData <= bus.p_data;
        bus.IAddr <= bus.p_pc;
      end else if (pop) begin
        bus.WAddr <= aq[rd];
        bus.WData <= dq[rd];
        bus.IAddr <= pq[rd];
      end
      // push into a full FIFO is impossible, so wr never lands on the slot being popped
      if (push) begin
        aq[wr] <= bus.m_addr;
        dq[wr] <= bus.m_data;
        pq[wr] <= bus.m_pc;
        v[wr] <= 1'b1;
        wr <= wr + AW'(1);
      end
      if (pop) begin
        v[rd] <= 1'b0;
        rd <= rd + AW'(1);
      end
      cnt <= cnt + 5'(push) - 5'(pop);
      wt <= (pop || cnt == 5'd0) ? '0 : (wt == WW'(STARVE_LIMIT) ? wt : wt + WW'(1));
    end
  end
`ifdef GRF_WRITE_TRACE_EN
  always_ff @(posedge clk)
    if (!reset && sel_p)
      $display("%0t@%h: $%0d <= %h", $time, bus.p_pc, bus.p_addr, bus.p_data);
    else if (!reset && pop)
      $display("%0t@%h: $%0d <= %h", $time, pq[rd], aq[rd], dq[rd]);
`endif
endmodule

// File: tb/tb_grf_write_sched.sv
// tb_grf_write_sched: queue-based reference model compared every cycle, plus directed literal checks.
module tb_grf_write_sched;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  typedef struct { logic [4:0] a; logic [31:0] d; logic [31:0] pc; } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  grf_write_sched_if bus();
  grf_write_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  ent_t q[$];
  logic e_we;
  logic [4:0] e_wa;
  logic [31:0] e_wd, e_ia;
  int e_wt;
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      e_we = 0; e_wa = 0; e_wd = 0; e_ia = 0; e_wt = 0;
    end else begin
      automatic int n = q.size();
      automatic bit rdy = n < DEPTH;
      automatic bit pipe = bus.p_valid && bus.p_addr != 0;
      automatic bit popped = !pipe && n > 0;
      e_we = pipe || popped;
      if (pipe) begin
        e_wa = bus.p_addr; e_wd = bus.p_data; e_ia = bus.p_pc;
      end else if (popped) begin
        e_wa = q[0].a; e_wd = q[0].d; e_ia = q[0].pc;
      end
      e_wt = (n == 0 || popped) ? 0 : (e_wt < LIMIT ? e_wt + 1 : LIMIT);
      if (popped) void'(q.pop_front());
      if (bus.m_valid && rdy && bus.m_addr != 0) q.push_back('{bus.m_addr, bus.m_data, bus.m_pc});
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit in_q(logic [4:0] a);
    foreach (q[i]) if (q[i].a == a) return a != 0;
    return 0;
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("m_WEnable", 32'(bus.WEnable), 32'(e_we));
    chk("m_WAddr", 32'(bus.WAddr), 32'(e_wa));
    chk("m_WData", bus.WData, e_wd);
    chk("m_IAddr", bus.IAddr, e_ia);
    chk("m_count", 32'(bus.count), 32'(q.size()));
    chk("m_ready", 32'(bus.m_ready), 32'(!reset && q.size() < DEPTH));
    chk("m_starve", 32'(bus.starve), 32'(e_wt == LIMIT));
    chk("m_hit1", 32'(bus.q_hit1), 32'(in_q(bus.q_addr1)));
    chk("m_hit2", 32'(bus.q_hit2), 32'(in_q(bus.q_addr2)));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pipe(logic v, logic [4:0] a, logic [31:0] d, logic [31:0] pc);
    bus.p_valid = v; bus.p_addr = a; bus.p_data = d; bus.p_pc = pc;
  endtask
  task automatic late(logic v, logic [4:0] a, logic [31:0] d, logic [31:0] pc);
    bus.m_valid = v; bus.m_addr = a; bus.m_data = d; bus.m_pc = pc;
  endtask
  initial begin
    pipe(0, 0, 0, 0);
    late(0, 0, 0, 0);
    bus.q_addr1 = 0; bus.q_addr2 = 0;
    step(); step();
    chk_en = 1;
    reset = 0;
    chk("rst_WEnable", 32'(bus.WEnable), 0);
    chk("rst_WAddr", 32'(bus.WAddr), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_starve", 32'(bus.starve), 0);
    // pipeline-only write
    pipe(1, 5, 32'h1234, 32'h3000);
    step();
    pipe(0, 0, 0, 0);
    chk("p_WEnable", 32'(bus.WEnable), 1);
    chk("p_WAddr", 32'(bus.WAddr), 5);
    chk("p_WData", bus.WData, 32'h00001234);
    chk("p_IAddr", bus.IAddr, 32'h00003000);
    // contention
    pipe(1, 3, 32'h11, 32'h200);
    late(1, 7, 32'hAA, 32'h300);
    step();
    pipe(0, 0, 0, 0);
    late(0, 0, 0, 0);
    chk("c_WAddr1", 32'(bus.WAddr), 3);
    step();
    chk("c_WAddr2", 32'(bus.WAddr), 7);
    chk("c_WData2", bus.WData, 32'hAA);
    chk("c_count", 32'(bus.count), 0);
    // fill with pipeline held high
    pipe(1, 9, 32'h99, 32'h900);
    for (int i = 1; i <= 4; i++) begin
      late(1, 5'(i), 32'(i * 16), 32'(32'h400 + i));
      step();
    end
    late(0, 0, 0, 0);
    bus.q_addr1 = 3; bus.q_addr2 = 0;
    #1;
    chk("f_count", 32'(bus.count), 4);
    chk("f_ready", 32'(bus.m_ready), 0);
    chk("f_hit3", 32'(bus.q_hit1), 1);
    chk("f_hit0", 32'(bus.q_hit2), 0);
    for (int i = 0; i < 4; i++) step();
    chk("f_starve7", 32'(bus.starve), 0);
    step();
    chk("f_starve8", 32'(bus.starve), 1);
    chk("f_pipe_wins", 32'(bus.WAddr), 9);
    // release; a late request in the popping cycle must still see m_ready low
    pipe(0, 0, 0, 0);
    late(1, 13, 32'hDD, 32'hD00);
    #1;
    chk("f_full_pop_ready", 32'(bus.m_ready), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      late(0, 0, 0, 0);
      chk("f_order", 32'(bus.WAddr), 32'(i));
      chk("f_order_we", 32'(bus.WEnable), 1);
    end
    chk("f_drained", 32'(bus.count), 0);
    bus.q_addr1 = 0;
    // zero register
    late(1, 6, 32'h66, 32'h600);
    step();
    late(0, 0, 0, 0);
    pipe(1, 0, 32'hBAD, 32'hBAD);
    step();
    pipe(0, 0, 0, 0);
    chk("z_head_WAddr", 32'(bus.WAddr), 6);
    chk("z_head_count", 32'(bus.count), 0);
    late(1, 0, 32'h77, 32'h700);
    #1;
    chk("z_m0_ready", 32'(bus.m_ready), 1);
    step();
    late(0, 0, 0, 0);
    chk("z_m0_count", 32'(bus.count), 0);
    step();
    chk("z_m0_noWE", 32'(bus.WEnable), 0);
    // reset mid-drain
    pipe(1, 20, 32'h20, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      late(1, 5'(10 + i), 32'(i), 32'(i));
      step();
    end
    late(0, 0, 0, 0);
    pipe(0, 0, 0, 0);
    chk("r_count3", 32'(bus.count), 3);
    reset = 1;
    step();
    chk("r_WEnable", 32'(bus.WEnable), 0);
    chk("r_count", 32'(bus.count), 0);
    chk("r_starve", 32'(bus.starve), 0);
    chk("r_ready", 32'(bus.m_ready), 0);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r_noissue", 32'(bus.WEnable), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/grf_write_sched.md
GRF_WRITE_SCHED -- requirements
Module: grf_write_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, late-write FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, cycles a FIFO head may wait before starve asserts.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port p_valid  input  1  pipeline write-back request, this cycle only.
REQ-006 The block SHALL have ports p_addr  input  5, p_data  input  32, p_pc  input  32: pipeline destination, value, instruction address.
REQ-007 The block SHALL have port m_valid  input  1  late (multi-cycle unit) write request.
REQ-008 The block SHALL have port m_ready  output  1  late request accepted this cycle when high with m_valid.
REQ-009 The block SHALL have ports m_addr  input  5, m_data  input  32, m_pc  input  32: late destination, value, instruction address.
REQ-010 The block SHALL have ports WEnable  output  1, WAddr  output  5, WData  output  32, IAddr  output  32: registered write port to the register file.
REQ-011 The block SHALL have ports q_addr1, q_addr2  input  5  and q_hit1, q_hit2  output  1: pending-write query for the decode-stage read addresses.
REQ-012 The block SHALL have port starve  output  1  request for upstream to idle p_valid.
REQ-013 The block SHALL have port count  output  5  number of valid FIFO entries.

Function
REQ-014 Each cycle the issue slot SHALL be selected by priority: (1) p_valid with p_addr!=0; (2) FIFO head if count>0; (3) none.
REQ-015 The selected write SHALL appear on WEnable/WAddr/WData/IAddr at the next rising edge (1-cycle latency); with no selection WEnable SHALL be 0 and the other outputs SHALL hold.
REQ-016 A pipeline request with p_addr==0 SHALL be dropped and SHALL leave the slot free for the FIFO.
REQ-017 m_ready SHALL equal (count<DEPTH); a pop in the same cycle SHALL NOT raise m_ready when full.
REQ-018 An accepted late request with m_addr==0 SHALL be consumed without enqueue.
REQ-019 An accepted late request SHALL be enqueued at the edge; earliest issue is the following cycle (no bypass), i.e. WEnable two edges after acceptance.
REQ-020 FIFO SHALL be strictly in order; read/write pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-021 q_hitN SHALL be 1 iff q_addrN!=0 and q_addrN matches any valid FIFO entry's address; combinational from current state. The output register is not included.
REQ-022 A wait counter SHALL increment each cycle count>0 and the head is not popped, saturate at STARVE_LIMIT, and clear on pop or when empty.
REQ-023 starve SHALL be 1 iff the wait counter equals STARVE_LIMIT; if p_valid is still asserted, the pipeline SHALL still win (REQ-014).

Reset
REQ-024 While reset is high at an edge: WEnable=0, WAddr=0, WData=0, IAddr=0, FIFO emptied (count=0), pointers=0, wait counter=0, starve=0.
REQ-025 Reset mid-operation SHALL discard all queued entries; no queued entry SHALL issue after reset.
REQ-026 During reset m_ready SHALL be 0 and requests SHALL be ignored.

Configuration
REQ-027 Macro GRF_WRITE_TRACE_EN: when defined, each edge that sets WEnable=1 SHALL print one line "<time>@<IAddr hex>: $<WAddr decimal> <= <WData hex>" for that write; when undefined, no print logic SHALL be compiled and function is identical.

Verification
REQ-028 Pipeline only: p_valid=1, p_addr=5, p_data=0x1234, p_pc=0x3000 -> next edge WEnable=1, WAddr=5, WData=0x00001234, IAddr=0x00003000.
REQ-029 Contention: same cycle p_valid (addr 3) and m_valid (addr 7, data 0xAA) -> edge1 WAddr=3; p_valid idle -> edge2 WAddr=7, WData=0xAA, count=0.
REQ-030 Fill: 4 late pushes (addr 1..4) with p_valid held high -> count=4, m_ready=0, q_hit for addr 3 =1, addr 0 =0; starve=1 after 8 waiting cycles; release p_valid -> writes 1,2,3,4 in order on 4 consecutive edges.
REQ-031 Zero register: p_addr=0 with count=1 -> FIFO head issues same edge; m_addr=0 accepted -> count unchanged, no WEnable.
REQ-032 Reset mid-drain: count=3, assert reset one cycle -> WEnable=0, count=0, starve=0; no queued address appears afterwards.
